// File: rtl/pump_fill_ctrl.sv
// Tank-fill sequencer: synchronised pins, FILL/HOLD/FAULT FSM, phase timer, saturating fill counter.
// Optional AUTO_REFILL_EN: IDLE enters FILL on a low tank without a start edge.
module pump_fill_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FILL_TIMEOUT = 1000,
  parameter int MIN_OFF      = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       lvl_high,
  input  logic       lvl_low,
  output logic       motor,
  output logic       full_flag,
  output logic       low_flag,
  output logic       alarm,
  output logic [1:0] state,
  output logic [7:0] fill_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);

  // Two-flop synchronisers; bit order {start, stop, lvl_high, lvl_low}
  logic [3:0] meta_q, sync_q;
  logic       start_s_d_q;
  logic       start_s, stop_s, lvl_high_s, lvl_low_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      start_s_d_q <= 1'b0;
    end else begin
      meta_q      <= {start, stop, lvl_high, lvl_low};
      sync_q      <= meta_q;
      start_s_d_q <= sync_q[3];
    end
  end

  assign start_s    = sync_q[3];
  assign stop_s     = sync_q[2];
  assign lvl_high_s = sync_q[1];
  assign lvl_low_s  = sync_q[0];

  logic start_rise, sfault;
  assign start_rise = start_s & ~start_s_d_q;
  assign sfault     = lvl_high_s & ~lvl_low_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             motor_q, motor_d;
  logic             alarm_q, alarm_d;
  logic             full_q, low_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sfault)
          state_d = FAULT;
        else if (start_rise && !lvl_high_s)
          state_d = FILL;
`ifdef AUTO_REFILL_EN
        else if (!lvl_low_s)
          state_d = FILL;
`endif
      end
      FILL: begin
        if (sfault)
          state_d = FAULT;
        else if (stop_s)
          state_d = HOLD;
        else if (lvl_high_s) begin
          state_d = HOLD;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (timer_q == TO_LAST)
          state_d = FAULT;
      end
      HOLD: begin
        if (sfault)
          state_d = FAULT;
        else if (timer_q == OFF_LAST)
          state_d = IDLE;
      end
      FAULT: begin
        if (stop_s && !sfault)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on every state entry and never wraps
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if ((state_q == FILL || state_q == HOLD) && timer_q != '1)
      timer_d = timer_q + 1'b1;

    motor_d = (state_d == FILL);
    alarm_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      motor_q <= 1'b0;
      alarm_q <= 1'b0;
      full_q  <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      motor_q <= motor_d;
      alarm_q <= alarm_d;
      full_q  <= lvl_high_s;
      low_q   <= ~lvl_low_s;
    end
  end

  assign motor      = motor_q;
  assign alarm      = alarm_q;
  assign full_flag  = full_q;
  assign low_flag   = low_q;
  assign state      = state_q;
  assign fill_count = cnt_q;

endmodule

// File: tb/tb_pump_fill_ctrl.sv
// Directed bench for pump_fill_ctrl with FILL_TIMEOUT=20, MIN_OFF=5.
module tb_pump_fill_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, lvl_high, lvl_low;
  logic       motor, full_flag, low_flag, alarm;
  logic [1:0] state;
  logic [7:0] fill_count;

  int checks = 0;
  int errors = 0;

  pump_fill_ctrl #(.CNT_W(16), .FILL_TIMEOUT(20), .MIN_OFF(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .lvl_high   (lvl_high),
    .lvl_low    (lvl_low),
    .motor      (motor),
    .full_flag  (full_flag),
    .low_flag   (low_flag),
    .alarm      (alarm),
    .state      (state),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; lvl_high = 1'b0; lvl_low = 1'b1;
    #12;
    chk("rst_state", state, 0);
    chk("rst_motor", motor, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_count", fill_count, 0);
    chk("rst_full", full_flag, 0);
    chk("rst_low", low_flag, 0);
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("idle_low_flag", low_flag, 0);
    chk("idle_state", state, 0);

    // Low tank alone must not start a fill when auto-refill is off
    lvl_low = 1'b0;
    tick(10);
    chk("lowtank_state", state, 0);
    chk("lowtank_flag", low_flag, 1);
    lvl_low = 1'b1;
    tick(3);

    // Normal fill: motor three edges after start, HOLD three edges after full
    start = 1'b1;
    tick(2);
    chk("fill_motor_e2", motor, 0);
    tick(1);
    chk("fill_motor_e3", motor, 1);
    chk("fill_state", state, 1);
    start = 1'b0;
    tick(7);
    lvl_high = 1'b1;
    tick(2);
    chk("full_e2_state", state, 1);
    tick(1);
    chk("full_state", state, 2);
    chk("full_motor", motor, 0);
    chk("full_count", fill_count, 1);
    chk("full_flag", full_flag, 1);
    lvl_high = 1'b0;
    tick(4);
    chk("hold_4", state, 2);
    tick(1);
    chk("hold_5_idle", state, 0);
    tick(2);

    // Timeout: 20 cycles in FILL, then FAULT
    pulse_start();
    tick(2);
    chk("to_fill", state, 1);
    tick(19);
    chk("to_fill_19", state, 1);
    tick(1);
    chk("to_state", state, 3);
    chk("to_alarm", alarm, 1);
    chk("to_motor", motor, 0);
    stop = 1'b1;
    tick(3);
    chk("to_clear_state", state, 0);
    chk("to_clear_alarm", alarm, 0);
    stop = 1'b0;
    tick(3);

    // Sensor fault during FILL
    pulse_start();
    tick(2);
    chk("sf_fill", state, 1);
    lvl_high = 1'b1; lvl_low = 1'b0;
    tick(3);
    chk("sf_state", state, 3);
    chk("sf_count", fill_count, 1);
    chk("sf_alarm", alarm, 1);
    stop = 1'b1;
    tick(4);
    chk("sf_stuck", state, 3);
    lvl_high = 1'b0; lvl_low = 1'b1;
    tick(3);
    chk("sf_clear", state, 0);
    chk("sf_clear_alarm", alarm, 0);
    stop = 1'b0;
    tick(3);

    // Abort by stop, then a start edge inside HOLD is ignored
    pulse_start();
    tick(2);
    chk("ab_fill", state, 1);
    stop = 1'b1;
    tick(3);
    chk("ab_hold", state, 2);
    chk("ab_count", fill_count, 1);
    chk("ab_motor", motor, 0);
    stop = 1'b0;
    pulse_start();
    tick(3);
    chk("ab_hold_start", state, 2);
    tick(4);
    chk("ab_idle", state, 0);
    chk("ab_idle_motor", motor, 0);

    // Start while the tank is full is ignored
    lvl_high = 1'b1;
    tick(3);
    pulse_start();
    tick(5);
    chk("full_start_state", state, 0);
    chk("full_start_motor", motor, 0);
    lvl_high = 1'b0;
    tick(3);

    // Async reset mid-FILL drops the motor before the next edge
    pulse_start();
    tick(2);
    chk("ar_motor_on", motor, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_motor_off", motor, 0);
    chk("ar_state", state, 0);
    chk("ar_count", fill_count, 0);
    tick(1);
    rst = 1'b0;
    tick(3);

    // 256 complete fills; the counter saturates at 255
    for (int i = 0; i < 256; i++) begin
      pulse_start();
      tick(2);
      lvl_high = 1'b1;
      tick(3);
      lvl_high = 1'b0;
      tick(5);
      if (i == 0)   chk("sat_first", fill_count, 1);
      if (i == 254) chk("sat_255", fill_count, 255);
    end
    chk("sat_256", fill_count, 255);
    chk("sat_idle", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
